// File: rtl/updown_counter_param_pkg.sv
// Shared definitions for the parametrised up/down counter family.
package updown_counter_param_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // What the count register does on a given edge, in priority order.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_STEP  = 2'd1,
        OP_LOAD  = 2'd2,
        OP_RESET = 2'd3
    } counter_op_e;

endpackage

// File: rtl/updown_counter_param_next.sv
// Combinational next-value and limit detection for one up/down counter channel.
// Arithmetic is done one bit wider than the count so MOD = 2**WIDTH is safe.
module updown_next
    import updown_counter_param_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             select,
    output logic [WIDTH-1:0] next_q,
    output logic             at_limit
);

    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(MOD - 1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] q_inc;
    logic [WIDTH:0] q_dec;

    assign q_ext = {1'b0, q};
    assign q_inc = q_ext + 1'b1;
    assign q_dec = q_ext - 1'b1;

    // Step one position in the selected direction, wrapping or holding at the limit.
    always_comb begin
        next_q   = q;
        at_limit = 1'b0;
        if (select == DIR_UP) begin
            at_limit = (q_ext == LIMIT);
            if (!at_limit) begin
                next_q = q_inc[WIDTH-1:0];
            end else if (SATURATE != MODE_SAT) begin
                next_q = '0;
            end
        end else begin
            at_limit = (q_ext == '0);
            if (!at_limit) begin
                next_q = q_dec[WIDTH-1:0];
            end else if (SATURATE != MODE_SAT) begin
                next_q = LIMIT[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with load, enable, wrap/saturate,
// terminal-count decode and a registered wrap pulse.
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             select,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(MOD - 1);

    generate
        if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
            $error("updown_counter_param: MOD=%0d out of range for WIDTH=%0d", MOD, WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] step_q;
    logic             step_at_limit;
    logic [WIDTH-1:0] load_clamped;
    counter_op_e      op;

    assign limit_q = LIMIT[WIDTH-1:0];

    updown_next #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .SATURATE (SATURATE)
    ) u_next (
        .q        (q),
        .select   (select),
        .next_q   (step_q),
        .at_limit (step_at_limit)
    );

    // Loads above the modulus are clamped so q can never leave 0..MOD-1.
    always_comb begin
        load_clamped = load_val;
        if ({1'b0, load_val} > LIMIT) begin
            load_clamped = limit_q;
        end
    end

    // Edge priority: reset, then load, then enable, otherwise hold.
    always_comb begin
        op = OP_HOLD;
        if (reset) begin
            op = OP_RESET;
        end else if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_STEP;
        end
    end

    // Count and wrap registers; wrap is a one-cycle pulse aligned with the new q.
    always_ff @(posedge clk) begin
        case (op)
            OP_RESET: begin
                q    <= '0;
                wrap <= 1'b0;
            end
            OP_LOAD: begin
                q    <= load_clamped;
                wrap <= 1'b0;
            end
            OP_STEP: begin
                q    <= step_q;
                wrap <= step_at_limit;
            end
            default: begin
                q    <= q;
                wrap <= 1'b0;
            end
        endcase
    end

    // Terminal count follows select immediately.
    always_comb begin
        if (select == DIR_UP) begin
            tc = (q == limit_q);
        end else begin
            tc = (q == '0);
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: three counter configurations driven in lockstep and
// compared against an arithmetic reference model plus directed expectations.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       select = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] q_a, q_b, q_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;

    logic [3:0] dut_q [3];
    logic       dut_tc [3];
    logic       dut_w [3];

    int checks = 0;
    int failures = 0;

    int mod_t [3] = '{16, 10, 16};
    bit sat_t [3] = '{1'b0, 1'b0, 1'b1};
    int exp_q [3] = '{0, 0, 0};
    int exp_w [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MOD(16), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .select(select), .load(load),
        .load_val(load_val), .q(q_a), .tc(tc_a), .wrap(wrap_a));

    updown_counter_param #(.WIDTH(4), .MOD(10), .SATURATE(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .select(select), .load(load),
        .load_val(load_val), .q(q_b), .tc(tc_b), .wrap(wrap_b));

    updown_counter_param #(.WIDTH(4), .MOD(16), .SATURATE(1)) dut_c (
        .clk(clk), .reset(reset), .en(en), .select(select), .load(load),
        .load_val(load_val), .q(q_c), .tc(tc_c), .wrap(wrap_c));

    assign dut_q[0] = q_a;   assign dut_q[1] = q_b;   assign dut_q[2] = q_c;
    assign dut_tc[0] = tc_a; assign dut_tc[1] = tc_b; assign dut_tc[2] = tc_c;
    assign dut_w[0] = wrap_a; assign dut_w[1] = wrap_b; assign dut_w[2] = wrap_c;

    // Reference behaviour for one edge, from the current inputs.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                exp_q[i] = 0;
                exp_w[i] = 0;
            end else if (load) begin
                exp_q[i] = (int'(load_val) > mod_t[i] - 1) ? mod_t[i] - 1 : int'(load_val);
                exp_w[i] = 0;
            end else if (en && !select) begin
                if (exp_q[i] == mod_t[i] - 1) begin
                    exp_w[i] = 1;
                    if (!sat_t[i]) exp_q[i] = 0;
                end else begin
                    exp_q[i] = exp_q[i] + 1;
                    exp_w[i] = 0;
                end
            end else if (en && select) begin
                if (exp_q[i] == 0) begin
                    exp_w[i] = 1;
                    if (!sat_t[i]) exp_q[i] = mod_t[i] - 1;
                end else begin
                    exp_q[i] = exp_q[i] - 1;
                    exp_w[i] = 0;
                end
            end else begin
                exp_w[i] = 0;
            end
        end
    endtask

    function automatic bit exp_tc(int i);
        return select ? (exp_q[i] == 0) : (exp_q[i] == mod_t[i] - 1);
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; select = 1'b0; load = 1'b0; load_val = 4'd7;
        tick();
        tick();
        checks++;
        if ({q_a, wrap_a, tc_a} !== {4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_up: q=%0d wrap=%b tc=%b, required q=0 wrap=0 tc=0", q_a, wrap_a, tc_a);
        end
        select = 1'b1;
        #1;
        checks++;
        if (tc_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_tc_down: tc=%b, required 1", tc_a);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dut_q[i], dut_w[i], dut_tc[i]} !== {4'(exp_q[i]), exp_w[i] != 0, exp_tc(i)}) begin
                failures++;
                $display("FAIL reset_model[%0d]: q=%0d w=%b tc=%b, required q=%0d w=%0d tc=%b",
                         i, dut_q[i], dut_w[i], dut_tc[i], exp_q[i], exp_w[i], exp_tc(i));
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_up_wrap();
        int seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        reset = 1'b1; en = 1'b0; load = 1'b0; select = 1'b0;
        tick();
        reset = 1'b0; en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({q_b, wrap_b, tc_b} !== {4'(seq[k]), k == 9, seq[k] == 9}) begin
                failures++;
                $display("FAIL up_wrap step %0d: q=%0d wrap=%b tc=%b, required q=%0d wrap=%b tc=%b",
                         k, q_b, wrap_b, tc_b, seq[k], k == 9, seq[k] == 9);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({dut_q[i], dut_w[i], dut_tc[i]} !== {4'(exp_q[i]), exp_w[i] != 0, exp_tc(i)}) begin
                    failures++;
                    $display("FAIL up_wrap_model[%0d]: q=%0d w=%b tc=%b, required q=%0d w=%0d tc=%b",
                             i, dut_q[i], dut_w[i], dut_tc[i], exp_q[i], exp_w[i], exp_tc(i));
                end
            end
        end
    endtask

    task automatic test_down_wrap();
        int seq_q [3] = '{0, 9, 8};
        int seq_w [3] = '{0, 1, 0};
        load_val = 4'd1; load = 1'b1; en = 1'b0;
        tick();
        checks++;
        if (q_b !== 4'd1) begin
            failures++;
            $display("FAIL down_load: q=%0d, required 1", q_b);
        end
        load = 1'b0; en = 1'b1; select = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({q_b, wrap_b} !== {4'(seq_q[k]), seq_w[k] != 0}) begin
                failures++;
                $display("FAIL down_wrap step %0d: q=%0d wrap=%b, required q=%0d wrap=%0d",
                         k, q_b, wrap_b, seq_q[k], seq_w[k]);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({dut_q[i], dut_w[i], dut_tc[i]} !== {4'(exp_q[i]), exp_w[i] != 0, exp_tc(i)}) begin
                    failures++;
                    $display("FAIL down_model[%0d]: q=%0d w=%b tc=%b, required q=%0d w=%0d tc=%b",
                             i, dut_q[i], dut_w[i], dut_tc[i], exp_q[i], exp_w[i], exp_tc(i));
                end
            end
        end
    endtask

    task automatic test_saturate();
        int seq_w [3] = '{0, 1, 1};
        select = 1'b0; load_val = 4'd14; load = 1'b1; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) select = 1'b1;
            tick();
            checks++;
            if (k < 3 && {q_c, wrap_c} !== {4'd15, seq_w[k] != 0}) begin
                failures++;
                $display("FAIL saturate step %0d: q=%0d wrap=%b, required q=15 wrap=%0d",
                         k, q_c, wrap_c, seq_w[k]);
            end else if (k == 3 && {q_c, wrap_c} !== {4'd14, 1'b0}) begin
                failures++;
                $display("FAIL saturate_down: q=%0d wrap=%b, required q=14 wrap=0", q_c, wrap_c);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({dut_q[i], dut_w[i], dut_tc[i]} !== {4'(exp_q[i]), exp_w[i] != 0, exp_tc(i)}) begin
                    failures++;
                    $display("FAIL saturate_model[%0d]: q=%0d w=%b tc=%b, required q=%0d w=%0d tc=%b",
                             i, dut_q[i], dut_w[i], dut_tc[i], exp_q[i], exp_w[i], exp_tc(i));
                end
            end
        end
    endtask

    task automatic test_load_clamp();
        select = 1'b0; load_val = 4'd13; load = 1'b1; en = 1'b1;
        tick();
        checks++;
        if ({q_b, q_a, wrap_b} !== {4'd9, 4'd13, 1'b0}) begin
            failures++;
            $display("FAIL load_clamp: q_b=%0d q_a=%0d wrap=%b, required q_b=9 q_a=13 wrap=0",
                     q_b, q_a, wrap_b);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({q_a, q_b, q_c} !== 12'd0) begin
            failures++;
            $display("FAIL load_vs_reset: q=%0d/%0d/%0d, required 0/0/0", q_a, q_b, q_c);
        end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_mid_reset();
        int seq_en [3] = '{1, 0, 1};
        int seq_q [3] = '{6, 6, 7};
        select = 1'b0; load_val = 4'd5; load = 1'b1; en = 1'b0;
        tick();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en = (seq_en[k] != 0);
            tick();
            checks++;
            if (q_b !== 4'(seq_q[k])) begin
                failures++;
                $display("FAIL enable_gate step %0d: q=%0d, required %0d", k, q_b, seq_q[k]);
            end
        end
        reset = 1'b1; en = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({q_b, wrap_b} !== {4'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: q=%0d wrap=%b, required q=0 wrap=0", q_b, wrap_b);
        end
        load_val = 4'd9; load = 1'b1; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        checks++;
        if ({q_b, wrap_b} !== {4'd0, 1'b1}) begin
            failures++;
            $display("FAIL pre_reset_wrap: q=%0d wrap=%b, required q=0 wrap=1", q_b, wrap_b);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b0;
        checks++;
        if ({q_b, wrap_b} !== {4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_drops_wrap: q=%0d wrap=%b, required q=0 wrap=0", q_b, wrap_b);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dut_q[i], dut_w[i], dut_tc[i]} !== {4'(exp_q[i]), exp_w[i] != 0, exp_tc(i)}) begin
                failures++;
                $display("FAIL mid_reset_model[%0d]: q=%0d w=%b tc=%b, required q=%0d w=%0d tc=%b",
                         i, dut_q[i], dut_w[i], dut_tc[i], exp_q[i], exp_w[i], exp_tc(i));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            select   = $urandom_range(0, 1) != 0;
            load_val = 4'($urandom_range(0, 15));
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_tc[i] !== exp_tc(i)) begin
                    failures++;
                    $display("FAIL rand_tc[%0d] iter %0d: tc=%b, required %b", i, n, dut_tc[i], exp_tc(i));
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({dut_q[i], dut_w[i]} !== {4'(exp_q[i]), exp_w[i] != 0}) begin
                    failures++;
                    $display("FAIL rand_model[%0d] iter %0d: q=%0d w=%b, required q=%0d w=%0d",
                             i, n, dut_q[i], dut_w[i], exp_q[i], exp_w[i]);
                end
            end
        end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load_clamp();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
